// File: rtl/mac_o_if.sv
// Handshake and data bundle between the data-fetch stage, the MAC stage and the activation stage.
interface mac_o_if #(
    parameter int DATA_W = 16
);
    logic                     in_rdy;
    logic                     df_rdy;
    logic signed [DATA_W-1:0] data_w;
    logic signed [DATA_W-1:0] data_i;
    logic        [DATA_W-1:0] data_o;
    logic                     out_rdy;
    logic                     busy;
    logic                     sat;

    modport master (
        output in_rdy, df_rdy, data_w, data_i,
        input  data_o, out_rdy, busy, sat
    );

    modport slave (
        input  in_rdy, df_rdy, data_w, data_i,
        output data_o, out_rdy, busy, sat
    );
endinterface

// File: rtl/mac_o.sv
// Output-neuron multiply-accumulate: sums N_IN signed products, rounds half up and rescales by FRAC.
// Define MAC_SAT_EN to clamp the result to the DATA_W range (and flag sat); otherwise it wraps.
//
// state | meaning
// IDLE  | waiting for in_rdy
// ACC   | accumulating one product per df_rdy cycle
// OUT   | one cycle, out_rdy high; in_rdy here starts the next evaluation
module mac_o #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int N_IN   = 15,
    parameter int ACC_W  = 2*DATA_W+4
) (
    input logic   clk,
    input logic   reset,
    mac_o_if.slave bus
);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN-1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2**(FRAC-1));

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0]    acc;
    logic        [CNT_W-1:0]    cnt;
    logic signed [2*DATA_W-1:0] w_ext, i_ext, prod;
    logic signed [ACC_W-1:0]    acc_sum, r;
    logic        [DATA_W-1:0]   res_nxt, data_q;
    logic                       accept, take, last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_rdy) state_nxt = ACC;
            ACC:     if (bus.df_rdy && cnt == CNT_LAST) state_nxt = OUT;
            OUT:     state_nxt = bus.in_rdy ? ACC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_rdy = (state == OUT);
        bus.busy    = (state != IDLE);
        accept      = bus.in_rdy && (state == IDLE || state == OUT);
        take        = bus.df_rdy && (state == ACC);
        last        = take && (cnt == CNT_LAST);
    end

    // The final sum is rounded on the edge that takes the last pair so data_o is valid alongside out_rdy.
    assign w_ext   = {{DATA_W{bus.data_w[DATA_W-1]}}, bus.data_w};
    assign i_ext   = {{DATA_W{bus.data_i[DATA_W-1]}}, bus.data_i};
    assign prod    = w_ext * i_ext;
    assign acc_sum = $signed(acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
    assign r       = (acc_sum + HALF) >>> FRAC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                acc <= '0;
                cnt <= '0;
            end else if (take) begin
                acc <= acc_sum;
                cnt <= last ? '0 : cnt + CNT_W'(1);
            end
            if (last) data_q <= res_nxt;
        end
    end

    assign bus.data_o = data_q;

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] R_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] R_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic sat_nxt, sat_q;

    always_comb begin
        res_nxt = r[DATA_W-1:0];
        sat_nxt = 1'b0;
        if (r > R_MAX) begin
            res_nxt = {1'b0, {(DATA_W-1){1'b1}}};
            sat_nxt = 1'b1;
        end else if (r < R_MIN) begin
            res_nxt = {1'b1, {(DATA_W-1){1'b0}}};
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     sat_q <= 1'b0;
        else if (last) sat_q <= sat_nxt;
    end

    assign bus.sat = sat_q;
`else
    logic unused_r;

    assign res_nxt  = r[DATA_W-1:0];
    assign bus.sat  = 1'b0;
    assign unused_r = ^r[ACC_W-1:DATA_W];
`endif
endmodule

// File: tb/tb_mac_o.sv
// Scoreboard bench for mac_o (DATA_W=16, FRAC=8, N_IN=15); follows MAC_SAT_EN for the overflow case.
module tb_mac_o;
    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    int   busy_drops = 0;
    bit   mon_busy = 1'b0;
    logic [15:0] exp_data_q[$];
    logic        exp_sat_q[$];

    mac_o_if #(.DATA_W(16)) bus ();

    mac_o #(.DATA_W(16), .FRAC(8), .N_IN(15), .ACC_W(36)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_rdy === 1'b1) n_out++;
        if (mon_busy && bus.busy !== 1'b1) busy_drops++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start();
        @(negedge clk);
        bus.in_rdy = 1'b1;
        bus.df_rdy = 1'b0;
    endtask

    // Drives n pairs (first pair w0/i0, rest w/i); gap inserts a bubble with in_rdy high before each later pair.
    task automatic feed(input logic [15:0] w0, input logic [15:0] i0, input logic [15:0] w,
                        input logic [15:0] i, input int n, input bit gap, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (bus.out_rdy === 1'b1) seen++;
            if (gap && k > 0) begin
                bus.df_rdy = 1'b0;
                bus.in_rdy = 1'b1;
                @(negedge clk);
                if (bus.out_rdy === 1'b1) seen++;
            end
            bus.in_rdy = 1'b0;
            bus.df_rdy = 1'b1;
            bus.data_w = (k == 0) ? w0 : w;
            bus.data_i = (k == 0) ? i0 : i;
        end
        @(negedge clk);
        bus.df_rdy = 1'b0;
        bus.in_rdy = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_rdy !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.in_rdy = 1'b0;
        bus.df_rdy = 1'b0;
        bus.data_w = '0;
        bus.data_i = '0;
        @(negedge clk);
        tests++; if (bus.out_rdy !== 1'b0) begin fails++; $display("FAIL reset_out_rdy: got %b want 0", bus.out_rdy); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.data_o !== 16'h0000) begin fails++; $display("FAIL reset_data_o: got %h want 0000", bus.data_o); end
        tests++; if (bus.sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", bus.sat); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int seen, lat;
        logic [15:0] ed;
        logic es;
        exp_data_q.push_back(16'h0F00); exp_sat_q.push_back(1'b0);
        start();
        feed(16'h0100, 16'h0100, 16'h0100, 16'h0100, 15, 1'b0, seen);
        wait_out(lat);
        ed = exp_data_q.pop_front(); es = exp_sat_q.pop_front();
        tests++; if (lat !== 0) begin fails++; $display("FAIL basic_latency: got %0d extra cycles want 0", lat); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL basic_data: got %h want %h", bus.data_o, ed); end
        tests++; if (bus.sat !== es) begin fails++; $display("FAIL basic_sat: got %b want %b", bus.sat, es); end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_busy_out: got %b want 1", bus.busy); end
        @(negedge clk);
        tests++; if (bus.out_rdy !== 1'b0) begin fails++; $display("FAIL basic_pulse: got %b want 0", bus.out_rdy); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_idle: got %b want 0", bus.busy); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL basic_hold: got %h want %h", bus.data_o, ed); end
    endtask

    task automatic test_bubbles();
        int seen, lat;
        logic [15:0] ed;
        logic es;
        exp_data_q.push_back(16'hE200); exp_sat_q.push_back(1'b0);
        start();
        feed(16'hFF00, 16'h0200, 16'hFF00, 16'h0200, 15, 1'b1, seen);
        wait_out(lat);
        ed = exp_data_q.pop_front(); es = exp_sat_q.pop_front();
        tests++; if (seen !== 0) begin fails++; $display("FAIL bubble_early_out: got %0d pulses want 0", seen); end
        tests++; if (lat !== 0) begin fails++; $display("FAIL bubble_latency: got %0d extra cycles want 0", lat); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL bubble_data: got %h want %h", bus.data_o, ed); end
        tests++; if (bus.sat !== es) begin fails++; $display("FAIL bubble_sat: got %b want %b", bus.sat, es); end
    endtask

    task automatic test_round();
        int seen, lat;
        logic [15:0] ed;
        logic es;
        @(negedge clk);
        bus.df_rdy = 1'b1;
        bus.data_w = 16'h7FFF;
        bus.data_i = 16'h7FFF;
        exp_data_q.push_back(16'h0001); exp_sat_q.push_back(1'b0);
        start();
        feed(16'h0001, 16'h0080, 16'h0000, 16'h0000, 15, 1'b0, seen);
        wait_out(lat);
        ed = exp_data_q.pop_front(); es = exp_sat_q.pop_front();
        tests++; if (lat !== 0) begin fails++; $display("FAIL round_latency: got %0d extra cycles want 0", lat); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL round_data: got %h want %h", bus.data_o, ed); end
        tests++; if (bus.sat !== es) begin fails++; $display("FAIL round_sat: got %b want %b", bus.sat, es); end
    endtask

    task automatic test_saturate();
        int seen, lat;
        logic [15:0] ed;
        logic es;
`ifdef MAC_SAT_EN
        exp_data_q.push_back(16'h7FFF); exp_sat_q.push_back(1'b1);
`else
        exp_data_q.push_back(16'hF100); exp_sat_q.push_back(1'b0);
`endif
        start();
        feed(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 15, 1'b0, seen);
        wait_out(lat);
        ed = exp_data_q.pop_front(); es = exp_sat_q.pop_front();
        tests++; if (lat !== 0) begin fails++; $display("FAIL sat_latency: got %0d extra cycles want 0", lat); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL sat_data: got %h want %h", bus.data_o, ed); end
        tests++; if (bus.sat !== es) begin fails++; $display("FAIL sat_flag: got %b want %b", bus.sat, es); end
    endtask

    task automatic test_reset_mid();
        int seen, lat, snap;
        logic [15:0] ed;
        start();
        feed(16'h0100, 16'h0100, 16'h0100, 16'h0100, 7, 1'b0, seen);
        #2 reset = 1'b1;
        snap = n_out;
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        tests++; if (bus.data_o !== 16'h0000) begin fails++; $display("FAIL abort_data: got %h want 0000", bus.data_o); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (n_out !== snap) begin fails++; $display("FAIL abort_no_out: got %0d pulses want %0d", n_out, snap); end
        exp_data_q.push_back(16'h0F00); exp_sat_q.push_back(1'b0);
        start();
        feed(16'h0100, 16'h0100, 16'h0100, 16'h0100, 15, 1'b0, seen);
        wait_out(lat);
        ed = exp_data_q.pop_front(); void'(exp_sat_q.pop_front());
        tests++; if (lat !== 0) begin fails++; $display("FAIL restart_latency: got %0d extra cycles want 0", lat); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL restart_data: got %h want %h", bus.data_o, ed); end
    endtask

    task automatic test_back_to_back();
        int seen, lat, snap;
        logic [15:0] ed;
        logic es;
        exp_data_q.push_back(16'h0F00); exp_sat_q.push_back(1'b0);
        exp_data_q.push_back(16'h0F00); exp_sat_q.push_back(1'b0);
        #1 snap = n_out;
        start();
        #1 mon_busy = 1'b1;
        feed(16'h0100, 16'h0100, 16'h0100, 16'h0100, 15, 1'b0, seen);
        wait_out(lat);
        ed = exp_data_q.pop_front(); es = exp_sat_q.pop_front();
        tests++; if (lat !== 0) begin fails++; $display("FAIL b2b_first_latency: got %0d extra cycles want 0", lat); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL b2b_first_data: got %h want %h", bus.data_o, ed); end
        tests++; if (bus.sat !== es) begin fails++; $display("FAIL b2b_first_sat: got %b want %b", bus.sat, es); end
        bus.in_rdy = 1'b1;
        feed(16'h0080, 16'h0200, 16'h0080, 16'h0200, 15, 1'b0, seen);
        wait_out(lat);
        ed = exp_data_q.pop_front(); es = exp_sat_q.pop_front();
        mon_busy = 1'b0;
        tests++; if (lat !== 0) begin fails++; $display("FAIL b2b_second_latency: got %0d extra cycles want 0", lat); end
        tests++; if (bus.data_o !== ed) begin fails++; $display("FAIL b2b_second_data: got %h want %h", bus.data_o, ed); end
        tests++; if (busy_drops !== 0) begin fails++; $display("FAIL b2b_busy: got %0d low cycles want 0", busy_drops); end
        #1;
        tests++; if (n_out - snap !== 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", n_out - snap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_round();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
